// File: rtl/c4_pkg.sv
// Shared board geometry, FSM states, scan directions and winner codes for the connect-four controller.
// Pure declarations: no latency.
// No flow control.
package c4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int CELLS   = ROWS * COLS;
  localparam int WIN_LEN = 4;

  // Scan directions through the last placed disc: horizontal, vertical, "\" and "/".
  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D1,
    DIR_D2
  } c4_dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PLACE,
    ST_CHECK,
    ST_OVER
  } c4_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Flat cell index; row 0 is the top row.
  function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return 6'(int'(row) * COLS + int'(col));
  endfunction

endpackage

// File: rtl/c4_run_counter.sv
// Length of the same-colour run through one cell along one direction, clipped at the board edges.
// Purely combinational, zero latency.
// No flow control.
module c4_run_counter
  import c4_pkg::*;
(
  input  logic [CELLS-1:0] board,
  input  logic [CELLS-1:0] empty,
  input  logic [5:0]       idx,
  input  logic             colour,
  input  c4_dir_e          dir,
  output logic [2:0]       run_len
);

  int         r0, c0, dr, dc, rr, cc, cnt;
  logic       fwd_stop, bwd_stop;
  logic [5:0] ci;

  // Walk up to WIN_LEN-1 cells each way from idx, stopping at the edge, a hole or the other colour.
  always_comb begin
    r0       = int'(idx) / COLS;
    c0       = int'(idx) % COLS;
    dr       = 0;
    dc       = 1;
    rr       = 0;
    cc       = 0;
    ci       = '0;
    cnt      = 1;
    fwd_stop = 1'b0;
    bwd_stop = 1'b0;
    case (dir)
      DIR_H:   begin dr = 0; dc = 1;  end
      DIR_V:   begin dr = 1; dc = 0;  end
      DIR_D1:  begin dr = 1; dc = 1;  end
      DIR_D2:  begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    for (int k = 1; k < WIN_LEN; k++) begin
      rr = r0 + k * dr;
      cc = c0 + k * dc;
      if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
        fwd_stop = 1'b1;
      end else begin
        ci = 6'(rr * COLS + cc);
        if (empty[ci] || board[ci] != colour) fwd_stop = 1'b1;
        else if (!fwd_stop) cnt = cnt + 1;
      end
    end
    for (int k = 1; k < WIN_LEN; k++) begin
      rr = r0 - k * dr;
      cc = c0 - k * dc;
      if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
        bwd_stop = 1'b1;
      end else begin
        ci = 6'(rr * COLS + cc);
        if (empty[ci] || board[ci] != colour) bwd_stop = 1'b1;
        else if (!bwd_stop) cnt = cnt + 1;
      end
    end
    run_len = 3'(cnt);
  end

endmodule

// File: rtl/connect_four_game_ctrl.sv
// Connect-four sequencer: cursor, disc drop into lowest free row, player alternation, win/draw detection.
// Drop takes SCAN 1..6 + PLACE 1 + CHECK up to 4 cycles; busy is high throughout.
// Buttons are ignored while busy or game over; new_game always wins and clears on the next edge.
module connect_four_game_ctrl
  import c4_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_drop,
  input  logic             new_game,
  output logic [CELLS-1:0] game_data,
  output logic [CELLS-1:0] empty,
  output logic [2:0]       cursor_col,
  output logic             cur_player,
  output logic             busy,
  output logic [1:0]       winner,
  output logic             game_over
);

  c4_state_e  state, state_nxt;
  c4_dir_e    dir;
  logic [2:0] row;
  logic [5:0] move_count;
  logic [5:0] cur_idx;
  logic [5:0] top_idx;
  logic [2:0] run_len;
  logic       col_open;
  logic       run_win;
  logic       last_dir;
  logic       board_full;

  // Row is held from SCAN through CHECK, so cur_idx is the placed cell during CHECK.
  assign cur_idx    = cell_idx(row, cursor_col);
  assign top_idx    = cell_idx(3'd0, cursor_col);
  assign col_open   = empty[top_idx];
  assign run_win    = run_len >= 3'(WIN_LEN);
  assign last_dir   = (dir == DIR_D2);
  assign board_full = (move_count == 6'(CELLS));
  assign busy       = (state == ST_SCAN) || (state == ST_PLACE) || (state == ST_CHECK);
  assign game_over  = (winner != WIN_NONE);

  c4_run_counter u_run (
    .board   (game_data),
    .empty   (empty),
    .idx     (cur_idx),
    .colour  (cur_player),
    .dir     (dir),
    .run_len (run_len)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; new_game overrides every state.
  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (btn_drop && col_open) state_nxt = ST_SCAN;
        ST_SCAN:  if (empty[cur_idx]) state_nxt = ST_PLACE;
        ST_PLACE: state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (run_win)       state_nxt = ST_OVER;
          else if (last_dir) state_nxt = board_full ? ST_OVER : ST_IDLE;
        end
        ST_OVER:  state_nxt = ST_OVER;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Board, cursor, turn and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_data  <= '0;
      empty      <= '1;
      cursor_col <= 3'd3;
      cur_player <= FIRST_PLAYER;
      winner     <= WIN_NONE;
      move_count <= '0;
      row        <= 3'(ROWS - 1);
      dir        <= DIR_H;
    end else if (new_game) begin
      game_data  <= '0;
      empty      <= '1;
      cursor_col <= 3'd3;
      cur_player <= FIRST_PLAYER;
      winner     <= WIN_NONE;
      move_count <= '0;
      row        <= 3'(ROWS - 1);
      dir        <= DIR_H;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_drop) begin
            if (col_open) begin
              row <= 3'(ROWS - 1);
              dir <= DIR_H;
            end
          end else if (btn_left && !btn_right) begin
            cursor_col <= (cursor_col == 3'd0) ? 3'(COLS - 1) : cursor_col - 3'd1;
          end else if (btn_right && !btn_left) begin
            cursor_col <= (cursor_col == 3'(COLS - 1)) ? 3'd0 : cursor_col + 3'd1;
          end
        end
        ST_SCAN: begin
          if (!empty[cur_idx]) row <= row - 3'd1;
        end
        ST_PLACE: begin
          empty[cur_idx]     <= 1'b0;
          game_data[cur_idx] <= cur_player;
          move_count         <= move_count + 6'd1;
        end
        ST_CHECK: begin
          if (run_win) begin
            winner <= cur_player ? WIN_P1 : WIN_P0;
          end else if (last_dir) begin
            if (board_full) winner <= WIN_DRAW;
            else            cur_player <= ~cur_player;
          end else begin
            dir <= c4_dir_e'(dir + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_connect_four_game_ctrl.sv
// Self-checking bench for connect_four_game_ctrl with a reference board model and a result scoreboard.
// Each drop pushes its predicted board/turn/busy length; the entry is popped when busy falls.
// All bounded waits report a failed check on expiry.
module tb_connect_four_game_ctrl;
  import c4_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_left, btn_right, btn_drop, new_game;
  logic [CELLS-1:0] game_data, empty;
  logic [2:0]       cursor_col;
  logic             cur_player, busy, game_over;
  logic [1:0]       winner;

  always #5 clk = ~clk;

  connect_four_game_ctrl #(.FIRST_PLAYER(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_drop   (btn_drop),
    .new_game   (new_game),
    .game_data  (game_data),
    .empty      (empty),
    .cursor_col (cursor_col),
    .cur_player (cur_player),
    .busy       (busy),
    .winner     (winner),
    .game_over  (game_over)
  );

  typedef struct {
    logic [CELLS-1:0] empty;
    logic [CELLS-1:0] data;
    int               busy_cyc;   // -1: not compared (winning move ends CHECK early)
    logic [1:0]       winner;
    logic             player;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CELLS-1:0] m_empty, m_data;
  int               m_cursor, m_moves;
  logic             m_player;
  logic [1:0]       m_winner;
  int               draw_seq[42];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [5:0] ix(input int r, input int c);
    return 6'(r * COLS + c);
  endfunction

  task automatic model_reset();
    m_empty  = '1;
    m_data   = '0;
    m_cursor = 3;
    m_player = 1'b0;
    m_winner = 2'b00;
    m_moves  = 0;
  endtask

  // Exhaustive window search over the whole model board.
  function automatic bit model_win(input logic col);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    bit ok;
    int rr, cc;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int k = 0; k < WIN_LEN; k++) begin
            rr = r + k * dr[d];
            cc = c + k * dc[d];
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
            else if (m_empty[ix(rr, cc)] || m_data[ix(rr, cc)] != col) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_left();
    btn_left = 1'b1; tick(); btn_left = 1'b0;
  endtask

  task automatic pulse_right();
    btn_right = 1'b1; tick(); btn_right = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1; tick(); new_game = 1'b0;
    model_reset();
  endtask

  task automatic do_drop(input int col);
    exp_t e, got_e;
    int   steps, row, cyc;
    steps = (col - m_cursor + COLS) % COLS;
    for (int i = 0; i < steps; i++) pulse_right();
    if (m_winner == 2'b00) m_cursor = col;
    chk("cursor_move", cursor_col, m_cursor);
    row = -1;
    if (m_winner == 2'b00)
      for (int r = 0; r < ROWS; r++)
        if (m_empty[ix(r, m_cursor)]) row = r;
    e.busy_cyc = 0;
    if (row >= 0) begin
      m_empty[ix(row, m_cursor)] = 1'b0;
      m_data[ix(row, m_cursor)]  = m_player;
      m_moves++;
      if (model_win(m_player)) begin
        m_winner   = m_player ? 2'b10 : 2'b01;
        e.busy_cyc = -1;
      end else begin
        e.busy_cyc = (ROWS - row) + 5;
        if (m_moves == CELLS) m_winner = 2'b11;
        else                  m_player = ~m_player;
      end
    end
    e.empty  = m_empty;
    e.data   = m_data;
    e.winner = m_winner;
    e.player = m_player;
    sb_q.push_back(e);

    btn_drop = 1'b1; tick(); btn_drop = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    if (cyc >= 40) chk("busy_timeout", 1, 0);
    got_e = sb_q.pop_front();
    if (got_e.busy_cyc >= 0) chk("busy_cycles", cyc, got_e.busy_cyc);
    chk("empty", empty, got_e.empty);
    chk("game_data", game_data & ~empty, got_e.data & ~got_e.empty);
    chk("winner", winner, got_e.winner);
    chk("game_over", game_over, got_e.winner != 2'b00);
    chk("cur_player", cur_player, got_e.player);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CELLS-1:0] mask;
    int               pairs_x[3] = '{0, 1, 4};
    int               pairs_y[3] = '{2, 3, 6};
    int               n;

    reset = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0; new_game = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk("rst_empty", empty, 42'h3FF_FFFF_FFFF);
    chk("rst_game_data", game_data, 0);
    chk("rst_cursor", cursor_col, 3);
    chk("rst_winner", winner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_player", cur_player, 0);
    chk("rst_game_over", game_over, 0);

    // Cursor movement and wrap.
    for (int i = 0; i < 3; i++) pulse_left();
    chk("cursor_left3", cursor_col, 0);
    pulse_left();
    chk("cursor_wrap_left", cursor_col, 6);
    pulse_right();
    chk("cursor_wrap_right", cursor_col, 0);
    btn_left = 1'b1; btn_right = 1'b1; tick(); btn_left = 1'b0; btn_right = 1'b0;
    chk("cursor_both", cursor_col, 0);

    // First drop lands bottom of column 3.
    pulse_new_game();
    chk("ng_cursor", cursor_col, 3);
    do_drop(3);
    chk("cell38_filled", empty[38], 0);
    chk("cell38_colour", game_data[38], 0);

    // Fill column 0; seventh drop must be rejected.
    pulse_new_game();
    for (int i = 0; i < 7; i++) do_drop(0);
    mask = '0;
    for (int r = 0; r < ROWS; r++) mask[ix(r, 0)] = 1'b1;
    chk("col0_cells", empty & mask, 0);
    chk("col0_busy_idle", busy, 0);

    // Vertical win for player 0, then drops and cursor ignored.
    pulse_new_game();
    for (int i = 0; i < 7; i++) do_drop(i % 2);
    chk("win_code", winner, 2'b01);
    chk("win_over", game_over, 1);
    do_drop(2);
    chk("over_cursor_held", cursor_col, 0);

    // new_game while the drop is still scanning.
    pulse_new_game();
    for (int i = 0; i < 3; i++) do_drop(2);
    btn_drop = 1'b1; tick(); btn_drop = 1'b0;
    chk("scan_busy", busy, 1);
    new_game = 1'b1; tick(); new_game = 1'b0;
    model_reset();
    chk("ng_scan_empty", empty, 42'h3FF_FFFF_FFFF);
    chk("ng_scan_busy", busy, 0);
    chk("ng_scan_player", cur_player, 0);
    chk("ng_scan_winner", winner, 0);
    do_drop(3);

    // Scripted full board without any four-in-a-row.
    pulse_new_game();
    n = 0;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 12; k++) begin
        draw_seq[n] = ((k % 4) == 0 || (k % 4) == 3) ? pairs_x[p] : pairs_y[p];
        n++;
      end
    for (int k = 0; k < 6; k++) begin
      draw_seq[n] = 5;
      n++;
    end
    for (int i = 0; i < 42; i++) do_drop(draw_seq[i]);
    chk("draw_winner", winner, 2'b11);
    chk("draw_full", empty, 0);
    do_drop(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
